// File: rtl/dcache_line_fill.sv
// Data-cache line-fill engine: fetches a 256-bit line as a 4-beat critical-word-first
// wrapped burst on a 64-bit bus, then writes the assembled line to the cache in one cycle.
module dcache_line_fill #(
  parameter int TO_LIMIT = 255,
  parameter int AW       = 38
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [AW-1:0] req_adr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cyc_o,
  output logic          stb_o,
  output logic          we_o,
  output logic [AW-1:0] adr_o,
  input  logic          ack_i,
  input  logic          err_i,
  input  logic [63:0]   dat_i,
  output logic          wr,
  output logic [31:0]   sel,
  output logic [AW-1:0] wadr,
  output logic [255:0]  line
);

  localparam int TW = $clog2(TO_LIMIT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_LIMIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_WRITE, S_DONE} state_t;

  state_t          r_state;
  logic [AW-6:0]   r_base;
  logic [1:0]      r_start;
  logic [1:0]      r_beat;
  logic [TW-1:0]   r_to_cnt;

  // 2-bit arithmetic gives the wrap within the line for free.
  logic [1:0]      w_word;
  logic [1:0]      w_next_word;

  assign w_word      = r_start + r_beat;
  assign w_next_word = w_word + 2'd1;
  assign we_o        = 1'b0;

  // NOTE: every register here is assigned with <= so all state updates on the same
  // edge see the pre-edge values; mixing in blocking assignments would reorder them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_base   <= '0;
      r_start  <= '0;
      r_beat   <= '0;
      r_to_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cyc_o    <= 1'b0;
      stb_o    <= 1'b0;
      adr_o    <= '0;
      wr       <= 1'b0;
      sel      <= '0;
      wadr     <= '0;
      line     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_base   <= req_adr[AW-1:5];
            r_start  <= req_adr[4:3];
            r_beat   <= 2'd0;
            r_to_cnt <= '0;
            busy     <= 1'b1;
            cyc_o    <= 1'b1;
            stb_o    <= 1'b1;
            err      <= 1'b0;
            adr_o    <= {req_adr[AW-1:3], 3'b000};
            r_state  <= S_BUS;
          end
        end

        S_BUS: begin
          // Bus error wins over a same-cycle ack; a timeout aborts the same way.
          if (err_i || (!ack_i && r_to_cnt == TO_LAST)) begin
            cyc_o   <= 1'b0;
            stb_o   <= 1'b0;
            err     <= 1'b1;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else if (ack_i) begin
            line[{w_word, 6'b000000} +: 64] <= dat_i;
            r_beat   <= r_beat + 2'd1;
            r_to_cnt <= '0;
            if (r_beat == 2'd3) begin
              cyc_o   <= 1'b0;
              stb_o   <= 1'b0;
              wr      <= 1'b1;
              sel     <= '1;
              wadr    <= {r_base, 5'b00000};
              r_state <= S_WRITE;
            end else begin
              adr_o <= {r_base, w_next_word, 3'b000};
            end
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        S_WRITE: begin
          wr      <= 1'b0;
          sel     <= '0;
          done    <= 1'b1;
          err     <= 1'b0;
          r_state <= S_DONE;
        end

        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_line_fill.sv
// Scoreboard bench for dcache_line_fill: expected bus addresses, cache writes and
// done/err results are queued as each fill is launched and popped as the DUT emits them.
module tb_dcache_line_fill;

  localparam int AW = 38;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req = 1'b0;
  logic [AW-1:0] req_adr = '0;
  logic          busy, done, err, cyc_o, stb_o, we_o, wr;
  logic [AW-1:0] adr_o, wadr;
  logic          ack_i = 1'b0;
  logic          err_i = 1'b0;
  logic [63:0]   dat_i = '0;
  logic [31:0]   sel;
  logic [255:0]  line;

  dcache_line_fill #(.TO_LIMIT(TO), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_adr(req_adr),
    .busy(busy), .done(done), .err(err),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
    .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i),
    .wr(wr), .sel(sel), .wadr(wadr), .line(line)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] adr;
    logic [255:0]  data;
  } wr_t;

  logic [AW-1:0] q_adr[$];
  wr_t           q_wr[$];
  logic          q_done[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected model: beat b goes to word (start+b)%4; n beats are acked on the bus.
  task automatic push_exp(input logic [AW-1:0] adr, input logic [255:0] d,
                          input int n, input bit ok);
    logic [AW-1:0] base;
    logic [1:0]    start, w;
    wr_t           e;
    base  = {adr[AW-1:5], 5'b00000};
    start = adr[4:3];
    e.adr  = base;
    e.data = '0;
    for (int b = 0; b < n; b++) begin
      w = start + 2'(b);
      q_adr.push_back(base | {w, 3'b000});
      e.data[w*64 +: 64] = d[b*64 +: 64];
    end
    if (ok) q_wr.push_back(e);
    q_done.push_back(!ok);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (cyc_o && stb_o && ack_i) begin
        check("we_o_low", we_o, 1'b0);
        if (q_adr.size() == 0) check("adr_unexpected", 1'b1, 1'b0);
        else check("adr_o", adr_o, q_adr.pop_front());
      end
      if (wr) begin
        if (q_wr.size() == 0) check("wr_unexpected", 1'b1, 1'b0);
        else begin
          wr_t e;
          e = q_wr.pop_front();
          check("wadr", wadr, e.adr);
          check("sel", sel, 32'hFFFF_FFFF);
          check("line", line, e.data);
        end
      end
      if (done) begin
        if (q_done.size() == 0) check("done_unexpected", 1'b1, 1'b0);
        else check("done_err", err, q_done.pop_front());
      end
    end
  end

  // One request; waits = idle cycles before each ack; err_beat<0 = no bus error;
  // to_mode = never ack, expect timeout abort.
  task automatic do_fill(input string tag, input logic [AW-1:0] adr, input logic [255:0] d,
                         input int waits, input int err_beat, input bit to_mode);
    int  n;
    bit  ok;
    n  = to_mode ? 0 : (err_beat >= 0 ? err_beat + 1 : 4);
    ok = !to_mode && err_beat < 0;
    push_exp(adr, d, n, ok);
    req = 1'b1;
    req_adr = adr;
    tick();
    req = 1'b0;
    check({tag, "_start"}, {busy, cyc_o, stb_o, err}, 4'b1110);
    if (to_mode) begin
      repeat (TO - 1) tick();
      check({tag, "_still_bus"}, {cyc_o, done}, 2'b10);
      tick();
      check({tag, "_to_abort"}, {cyc_o, wr, done, err}, 4'b0011);
    end else begin
      for (int b = 0; b < n; b++) begin
        repeat (waits) tick();
        ack_i = 1'b1;
        err_i = (b == err_beat);
        dat_i = d[b*64 +: 64];
        tick();
        ack_i = 1'b0;
        err_i = 1'b0;
      end
      if (ok) begin
        check({tag, "_wr"}, {cyc_o, wr, done}, 3'b010);
        tick();
        check({tag, "_done"}, {busy, wr, done, err, sel}, {4'b1010, 32'h0});
      end else begin
        check({tag, "_err_abort"}, {cyc_o, wr, done, err}, 4'b0011);
      end
    end
    tick();
    check({tag, "_idle"}, {busy, done, err, wr}, {2'b00, !ok, 1'b0});
  endtask

  logic [255:0] d_a, d_b, d_c, d_d, d_e;

  initial begin
    d_a = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    d_b = {64'hB3B3_0000_0000_00B3, 64'hB2, 64'hB1, 64'hB0B0_1111_2222_3333};
    d_c = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
    d_d = {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
           64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000};
    d_e = {64'hE3, 64'hE2, 64'hE1, 64'hE0};

    tick();
    tick();
    check("rst_ctrl", {busy, done, err, cyc_o, stb_o, wr, sel}, '0);
    check("rst_adr", {adr_o, wadr}, '0);
    check("rst_line", line, '0);
    rst = 1'b1;
    tick();

    // Aligned zero-wait fill; wr lands in cycle 5, done in cycle 6.
    do_fill("aligned", 38'h00_0001_2340, d_a, 0, -1, 1'b0);
    // Critical word 2, ack every second cycle: order 2,3,0,1.
    do_fill("wrapped", 38'h00_0001_2350, d_b, 1, -1, 1'b0);
    // Bus error together with ack on beat 2, then a clean fill.
    do_fill("buserr", 38'h00_0001_2340, d_c, 0, 2, 1'b0);
    do_fill("after_err", 38'h2A_BCDE_F668, d_d, 0, -1, 1'b0);
    // Timeout after exactly TO cycles without ack.
    do_fill("timeout", 38'h00_0000_0018, d_c, 0, -1, 1'b1);
    do_fill("after_to", 38'h3F_FFFF_FFE0, d_e, 2, -1, 1'b0);

    // req held high: second fill is accepted only once IDLE is back (cycle 7).
    push_exp(38'h00_0001_2340, d_a, 4, 1'b1);
    push_exp(38'h00_0001_2348, d_e, 4, 1'b1);
    req = 1'b1;
    req_adr = 38'h00_0001_2340;
    tick();
    req_adr = 38'h00_0001_2348;
    for (int b = 0; b < 4; b++) begin
      ack_i = 1'b1;
      dat_i = d_a[b*64 +: 64];
      tick();
    end
    ack_i = 1'b0;
    check("hold_c5_wr", wr, 1'b1);
    tick();
    check("hold_c6_done", {busy, done}, 2'b11);
    tick();
    check("hold_c7_idle", {busy, cyc_o}, 2'b00);
    tick();
    req = 1'b0;
    check("hold_c8_restart", {busy, cyc_o, adr_o}, {2'b11, 38'h00_0001_2348});
    for (int b = 0; b < 4; b++) begin
      ack_i = 1'b1;
      dat_i = d_e[b*64 +: 64];
      tick();
    end
    ack_i = 1'b0;
    check("hold2_wr", wr, 1'b1);
    repeat (4) tick();
    check("hold2_idle", {busy, cyc_o, done}, 3'b000);

    // Asynchronous reset during beat 1.
    q_adr.push_back(38'h00_0001_2340);
    req = 1'b1;
    req_adr = 38'h00_0001_2340;
    tick();
    req = 1'b0;
    ack_i = 1'b1;
    dat_i = 64'h1234;
    tick();
    ack_i = 1'b0;
    check("rstmid_bus", {cyc_o, stb_o}, 2'b11);
    #2 rst = 1'b0;
    #1 check("rstmid_async", {cyc_o, stb_o, busy}, 3'b000);
    tick();
    tick();
    rst = 1'b1;
    repeat (10) tick();
    check("rstmid_after", {busy, cyc_o, stb_o, wr, done}, 5'b00000);

    check("queues_empty", q_adr.size() + q_wr.size() + q_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
